// File: rtl/fnd_pkg.sv
// Shared constants, segment codes and helpers for the FND scan driver.
// Used by bin2bcd_seq and fnd_scan_driver.
package fnd_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int VALUE_W     = 14;
  localparam int BCD_W       = 16;
  localparam int SH_W        = VALUE_W + BCD_W;
  localparam int MAX_DISPLAY = 9999;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } conv_state_t;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One shift-add-3 step: BCD nibbles sit above the binary field.
  function automatic logic [SH_W-1:0] dabble_step(
    input logic [SH_W-1:0] s
  );
    logic [SH_W-1:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[VALUE_W+4*i +: 4] >= 4'd5)
        t[VALUE_W+4*i +: 4] = t[VALUE_W+4*i +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter with capture/pending and saturation.
// Ports: i_clk, i_reset(n), i_value/i_valid in; o_busy, o_overflow, o_bcd out.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_valid,
  output logic               o_busy,
  output logic               o_overflow,
  output logic [BCD_W-1:0]   o_bcd
);

  conv_state_t        r_state;
  conv_state_t        w_next;
  logic [VALUE_W-1:0] r_cap;
  logic               r_pend;
  logic [SH_W-1:0]    r_sh;
  logic [3:0]         r_cnt;
  logic               r_big;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               w_load;
  logic [VALUE_W-1:0] w_src;
  logic               w_last;

  assign w_load = (r_state == ST_IDLE) && (i_valid || r_pend);
  // A fresh strobe in IDLE is newer than anything pending.
  assign w_src  = i_valid ? i_value : r_cap;
  assign w_last = (r_cnt == 4'(VALUE_W - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_load) w_next = ST_CONV;
      ST_CONV:   if (w_last) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cap  <= '0;
      r_pend <= 1'b0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_big  <= 1'b0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_valid) r_cap <= i_value;
      if (i_valid && r_state != ST_IDLE) r_pend <= 1'b1;
      else if (w_load)                   r_pend <= 1'b0;
      if (w_load) begin
        r_sh  <= {{BCD_W{1'b0}}, w_src};
        // 16383 wraps in 16 BCD bits, so saturate from binary.
        r_big <= (w_src > VALUE_W'(MAX_DISPLAY));
        r_cnt <= '0;
      end
      if (r_state == ST_CONV) begin
        r_sh  <= dabble_step(r_sh);
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == ST_COMMIT) begin
        r_bcd <= r_big ? 16'h9999 : r_sh[SH_W-1 -: BCD_W];
        r_ovf <= r_big;
      end
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_overflow = r_ovf;
  assign o_bcd      = r_bcd;

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode FND scan driver fed by a sequential BCD converter.
// Ports: i_clk, i_reset(n), i_value, i_valid; o_busy, o_overflow, o_fnd_com, o_fnd_font.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_valid,
  output logic               o_busy,
  output logic               o_overflow,
  output logic [3:0]         o_fnd_com,
  output logic [7:0]         o_fnd_font
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [3:0]       r_com;
  logic [7:0]       r_font;
  logic [BCD_W-1:0] w_bcd;
  logic             w_wrap;
  logic [3:0]       w_zero;
  logic [3:0]       w_blank;
  logic [3:0]       w_digit;
  logic [7:0]       w_font;

  bin2bcd_seq u_conv (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_value    (i_value),
    .i_valid    (i_valid),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_bcd      (w_bcd)
  );

  assign w_wrap = (r_pre == PRE_W'(SCAN_DIV - 1));

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++)
      w_zero[k] = (w_bcd[4*k +: 4] == 4'd0);
  end

  // A digit blanks only if it and every higher digit are zero.
  assign w_blank[3] = BLANK_LZ && w_zero[3];
  assign w_blank[2] = w_blank[3] && w_zero[2];
  assign w_blank[1] = w_blank[2] && w_zero[1];
  assign w_blank[0] = 1'b0;

  assign w_digit = w_bcd[4*r_idx +: 4];
  assign w_font  = w_blank[r_idx] ? SEG_BLANK : seg_of(w_digit);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_com  <= 4'b1110;
      r_font <= SEG_0;
    end else begin
      r_pre  <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_idx <= r_idx + 2'd1;
      r_com  <= ~(4'b0001 << r_idx);
      r_font <= w_font;
    end
  end

  assign o_fnd_com  = r_com;
  assign o_fnd_font = r_font;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized self-checking bench for fnd_scan_driver (SCAN_DIV=4).
// Two instances: leading-zero blanking on and off.
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        valid;
  logic        busy1, ovf1, busy0, ovf0;
  logic [3:0]  com1, com0;
  logic [7:0]  font1, font0;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  fnd_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut_lz (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_value    (value),
    .i_valid    (valid),
    .o_busy     (busy1),
    .o_overflow (ovf1),
    .o_fnd_com  (com1),
    .o_fnd_font (font1)
  );

  fnd_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_dut_all (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_value    (value),
    .i_valid    (valid),
    .o_busy     (busy0),
    .o_overflow (ovf0),
    .o_fnd_com  (com0),
    .o_fnd_font (font0)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_font(int v, int k, bit blz);
    int s, p;
    s = (v > 9999) ? 9999 : v;
    p = 10 ** k;
    if (blz && k > 0 && s < p) return 8'hFF;
    return seg_tab[(s / p) % 10];
  endfunction

  function automatic int com_idx(logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic send(int v);
    @(negedge clk);
    value = v[13:0];
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_scan(int v);
    int k1, k0;
    repeat (2) @(negedge clk);
    chk("ovf_lz", ovf1, v > 9999);
    chk("ovf_all", ovf0, v > 9999);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k1 = com_idx(com1);
      k0 = com_idx(com0);
      chk("com_lz_onehot", k1 >= 0, 1);
      chk("com_all_onehot", k0 >= 0, 1);
      if (k1 >= 0) chk("font_lz", font1, model_font(v, k1, 1'b1));
      if (k0 >= 0) chk("font_all", font0, model_font(v, k0, 1'b0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc, v, v2, nb, rises, first, last, lastc, k;
    logic pb;
    logic [3:0] prev, expc;

    rst_n = 1'b0;
    valid = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    chk("rst_com", com1, 4'b1110);
    chk("rst_font", font1, 8'hC0);
    chk("rst_busy", busy1, 0);
    chk("rst_ovf", ovf1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_scan(0);

    send(1234);
    wait_idle(cyc);
    chk("busy_len_1234", cyc, 15);
    check_scan(1234);

    send(16383);
    wait_idle(cyc);
    chk("busy_len_16383", cyc, 15);
    check_scan(16383);

    send(42);
    wait_idle(cyc);
    check_scan(42);

    // 5 at c=0, 7 at c=2, 8 at c=5: 7 must be superseded.
    nb = 0; rises = 0; first = -1; last = -1; pb = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy1) begin
        nb++;
        if (!pb) rises++;
        if (first < 0) first = c;
        last = c;
      end
      pb = busy1;
      valid = (c == 0 || c == 2 || c == 5);
      value = (c == 0) ? 14'd5 : (c == 2) ? 14'd7 : 14'd8;
    end
    valid = 1'b0;
    chk("pend_rises", rises, 2);
    chk("pend_busy_cycles", nb, 30);
    chk("pend_first", first, 1);
    // 15 busy + 1 idle + 15 busy.
    chk("pend_span", last - first + 1, 31);
    check_scan(8);

    repeat (6) begin
      v = $urandom_range(0, 16383);
      if ($urandom_range(0, 1) == 1) v = v % 10000;
      send(v);
      wait_idle(cyc);
      chk("busy_len_rand", cyc, 15);
      check_scan(v);
    end

    repeat (3) begin
      v  = $urandom_range(0, 16383);
      v2 = $urandom_range(0, 9999);
      send(v);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      send(v2);
      repeat (40) @(negedge clk);
      chk("super_idle", busy1, 0);
      check_scan(v2);
    end

    send(7);
    wait_idle(cyc);
    check_scan(7);
    prev = com0;
    lastc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (com0 != prev) begin
        k = com_idx(prev);
        expc = ~(4'b0001 << ((k + 1) % 4));
        chk("rot_order", com0, expc);
        if (lastc >= 0) chk("rot_gap", c - lastc, 4);
        lastc = c;
        prev = com0;
      end
    end
    chk("rot_seen", lastc >= 0, 1);

    send(16383);
    wait_idle(cyc);
    send(9999);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_com", com1, 4'b1110);
    chk("midrst_font_lz", font1, 8'hC0);
    chk("midrst_font_all", font0, 8'hC0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_ovf", ovf1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy1) nb++;
    end
    chk("midrst_no_conv", nb, 0);
    check_scan(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
